// File: rtl/trace_buffer.sv
// Instruction-trace capture: samples retired pc/inst with a cycle stamp into a
// first-word-fall-through FIFO, with a PC-match trigger that freezes capture.
module trace_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned POST  = 4
) (
    input  logic                       clk_in,
    input  logic                       reset_n,
    input  logic                       cap_en,
    input  logic                       clear,
    input  logic [31:0]                pc,
    input  logic [31:0]                inst,
    input  logic                       trig_en,
    input  logic [31:0]                trig_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic [15:0]                out_stamp,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [15:0]                overflow_cnt,
    output logic                       triggered,
    output logic                       frozen
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_POST,
        ST_FROZEN
    } state_t;

    state_t        state;
    logic [79:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [15:0]   stamp;
    logic [AW-1:0] post_cnt;
    logic [15:0]   ovf_q;
    logic          trig_q;

    logic          capture;
    logic          pop;
    logic          push;
    logic          drop;
    logic          hit;
    logic [79:0]   head;

    always_comb begin
        capture = cap_en && (state == ST_RUN || state == ST_POST);
        pop     = (count_q != '0) && out_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push    = capture && ((count_q != CW'(DEPTH)) || pop);
        drop    = capture && (count_q == CW'(DEPTH)) && !pop;
        hit     = trig_en && (pc == trig_pc) && (state == ST_RUN);
    end

    always_ff @(posedge clk_in) begin
        if (push && !clear) begin
            mem[wr_ptr] <= {pc, inst, stamp};
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            stamp    <= '0;
            post_cnt <= '0;
            ovf_q    <= '0;
            trig_q   <= 1'b0;
        end else if (clear) begin
            state    <= ST_IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            stamp    <= '0;
            post_cnt <= '0;
            ovf_q    <= '0;
            trig_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            if (drop && ovf_q != 16'hFFFF) begin
                ovf_q <= ovf_q + 16'd1;
            end
            if (capture) begin
                stamp <= stamp + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (cap_en) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!cap_en) begin
                        state <= ST_IDLE;
                    end else if (hit) begin
                        trig_q   <= 1'b1;
                        post_cnt <= AW'(POST);
                        state    <= (POST == 0) ? ST_FROZEN : ST_POST;
                    end
                end
                ST_POST: begin
                    if (!cap_en) begin
                        state <= ST_IDLE;
                    end else begin
                        post_cnt <= post_cnt - 1'b1;
                        if (post_cnt == AW'(1)) begin
                            state <= ST_FROZEN;
                        end
                    end
                end
                default: state <= ST_FROZEN;
            endcase
        end
    end

    // Head fields read straight from registered storage; forced to zero while empty.
    always_comb begin
        head      = mem[rd_ptr];
        out_valid = (count_q != '0);
        out_pc    = out_valid ? head[79:48] : '0;
        out_inst  = out_valid ? head[47:16] : '0;
        out_stamp = out_valid ? head[15:0]  : '0;
    end

    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign overflow_cnt = ovf_q;
    assign triggered    = trig_q;
    assign frozen       = (state == ST_FROZEN);

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: fill/overflow/drain, trigger window,
// full push+pop, clear during POST and stamp wrap.
module tb_trace_buffer;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        cap_en;
    logic        clear;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        trig_en;
    logic [31:0] trig_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [15:0] out_stamp;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] overflow_cnt;
    logic        triggered;
    logic        frozen;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    trace_buffer #(.DEPTH(16), .POST(4)) dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .cap_en       (cap_en),
        .clear        (clear),
        .pc           (pc),
        .inst         (inst),
        .trig_en      (trig_en),
        .trig_pc      (trig_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_stamp    (out_stamp),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow_cnt (overflow_cnt),
        .triggered    (triggered),
        .frozen       (frozen)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] p);
        return p ^ 32'h1357_9BDF;
    endfunction

    task automatic set_pc(input logic [31:0] p);
        pc   = p;
        inst = inst_of(p);
    endtask

    initial begin
        logic [31:0] last;
        int unsigned drained;
        int unsigned seen;
        int unsigned gaps;
        int unsigned wraps;
        logic [15:0] prev;
        logic        have_prev;

        reset_n = 1'b0; cap_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
        trig_en = 1'b0; trig_pc = '0;
        set_pc(BASE);

        // Reset state
        repeat (5) step();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow_cnt), 32'd0);
        check("rst_trig", 32'(triggered), 32'd0);
        check("rst_frozen", 32'(frozen), 32'd0);
        check("rst_head", out_pc | out_inst | 32'(out_stamp), 32'd0);
        reset_n = 1'b1;
        step();

        // Fill, overflow, drain
        cap_en = 1'b1;
        step();
        check("idle_to_run_no_sample", 32'(count), 32'd0);
        for (int i = 0; i < 16; i++) begin
            set_pc(BASE + 32'(4 * i));
            step();
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        check("fill_ovf0", 32'(overflow_cnt), 32'd0);
        for (int i = 16; i < 19; i++) begin
            set_pc(BASE + 32'(4 * i));
            step();
        end
        check("ovf3", 32'(overflow_cnt), 32'd3);
        check("ovf_count", 32'(count), 32'd16);
        cap_en = 1'b0;
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_pc", out_pc, BASE + 32'(4 * i));
            check("drain_inst", out_inst, inst_of(BASE + 32'(4 * i)));
            check("drain_stamp", 32'(out_stamp), 32'(i));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_ovf_kept", 32'(overflow_cnt), 32'd3);

        // Trigger window
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_ovf", 32'(overflow_cnt), 32'd0);
        trig_en = 1'b1; trig_pc = BASE + 32'h10; out_ready = 1'b1; cap_en = 1'b1;
        step();
        drained = 0; last = '0;
        for (int c = 0; c < 15; c++) begin
            set_pc(BASE + 32'(4 * c));
            if (out_valid) begin
                last = out_pc;
                drained++;
            end
            step();
            if (c == 3) check("pre_trig", 32'(triggered), 32'd0);
            if (c == 4) begin
                check("trig_set", 32'(triggered), 32'd1);
                check("trig_not_frozen", 32'(frozen), 32'd0);
            end
            if (c == 7) check("post_not_frozen", 32'(frozen), 32'd0);
            if (c == 8) check("post_frozen", 32'(frozen), 32'd1);
        end
        check("win_drained", drained, 32'd9);
        check("win_last", last, BASE + 32'h20);
        check("win_count", 32'(count), 32'd0);
        check("win_trig", 32'(triggered), 32'd1);
        cap_en = 1'b0;
        step();
        check("frozen_capen0", 32'(frozen), 32'd1);

        // Full FIFO with simultaneous push and pop
        clear = 1'b1; trig_en = 1'b0; out_ready = 1'b0;
        step();
        clear = 1'b0; cap_en = 1'b1;
        check("clr_unfrozen", 32'(frozen), 32'd0);
        step();
        for (int i = 0; i < 16; i++) begin
            set_pc(BASE + 32'(4 * i));
            step();
        end
        check("pp_full", 32'(count), 32'd16);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_pc(BASE + 32'(4 * (16 + k)));
            check("pp_head", out_pc, BASE + 32'(4 * k));
            step();
            check("pp_count", 32'(count), 32'd16);
        end
        check("pp_ovf", 32'(overflow_cnt), 32'd0);
        check("pp_next_head", out_pc, BASE + 32'h20);

        // Clear during POST with a pop requested
        clear = 1'b1; cap_en = 1'b0; out_ready = 1'b0;
        step();
        clear = 1'b0;
        trig_pc = BASE + 32'h8; trig_en = 1'b1; cap_en = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            set_pc(BASE + 32'(4 * i));
            step();
        end
        check("cp_count4", 32'(count), 32'd4);
        check("cp_trig", 32'(triggered), 32'd1);
        out_ready = 1'b1; clear = 1'b1;
        set_pc(BASE + 32'h10);
        step();
        clear = 1'b0; out_ready = 1'b0;
        check("cp_count0", 32'(count), 32'd0);
        check("cp_empty", 32'(empty), 32'd1);
        check("cp_trig0", 32'(triggered), 32'd0);
        check("cp_ovf0", 32'(overflow_cnt), 32'd0);
        check("cp_valid0", 32'(out_valid), 32'd0);
        step();
        check("cp_idle_no_sample", 32'(count), 32'd0);
        set_pc(BASE + 32'h100);
        step();
        check("cp_first_count", 32'(count), 32'd1);
        check("cp_first_stamp", 32'(out_stamp), 32'd0);
        check("cp_first_pc", out_pc, BASE + 32'h100);

        // Stamp wrap with continuous draining
        clear = 1'b1; cap_en = 1'b0; trig_en = 1'b0;
        step();
        clear = 1'b0; cap_en = 1'b1; out_ready = 1'b1;
        step();
        seen = 0; gaps = 0; wraps = 0; prev = '0; have_prev = 1'b0;
        for (int n = 0; n < 65540; n++) begin
            set_pc(32'(n * 4));
            if (out_valid) begin
                if (have_prev && out_stamp != 16'(prev + 16'd1)) gaps++;
                if (have_prev && prev == 16'hFFFF && out_stamp == 16'h0000) wraps++;
                prev = out_stamp;
                have_prev = 1'b1;
                seen++;
            end
            step();
        end
        check("wrap_gaps", gaps, 32'd0);
        check("wrap_count", wraps, 32'd1);
        check("wrap_seen", seen, 32'd65539);
        check("wrap_occupancy", 32'(count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
